// File: rtl/ls_mem_responder.sv
// Serialises one load/store request into byte accesses on the single-port RAM bus.
// Load bytes are assembled little-endian and zero-extended; completion is a one-cycle pulse.
module ls_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rdy_data_ls_in,
  input  logic                  wr_ls_in,
  input  logic [ADDR_WIDTH-1:0] addr_ls_in,
  input  logic [2:0]            len_ls_in,
  input  logic [DATA_WIDTH-1:0] data_s_ls_in,
  output logic [DATA_WIDTH-1:0] data_l_ls_out,
  output logic                  rdy_data_ls_out,
  input  logic                  refresh_rob_cdb_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d, len_q, len_d, len_n, k;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next, mem_a_q, mem_a_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, res_q, res_d, res_cap, data_l_q, data_l_d;
  logic [7:0]            mem_dout_q, mem_dout_d, st_byte;
  logic                  mem_wr_q, mem_wr_d, pulse_q, pulse_d, wflush_q, wflush_d, io_stall;

  assign len_n     = (len_ls_in >= 3'd1 && len_ls_in <= 3'd4) ? len_ls_in : 3'd4;
  assign k         = cnt_q + 3'd1;
  assign addr_next = addr_q + ADDR_WIDTH'(k);
  assign st_byte   = data_q[{k[1:0], 3'b000} +: 8];
  assign io_stall  = (mem_a_q[17:16] == 2'b11) && io_buffer_full;

  always_comb begin
    res_cap = res_q;
    res_cap[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    data_d     = data_q;
    res_d      = res_q;
    wflush_d   = wflush_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    pulse_d    = 1'b0;
    data_l_d   = data_l_q;
    if (!rdy_in) begin
      // Frozen cycle: keep a pending pulse; a dropped write strobe is re-issued later.
      pulse_d = pulse_q;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rdy_data_ls_in && !refresh_rob_cdb_in) begin
            addr_d   = addr_ls_in;
            len_d    = len_n;
            data_d   = data_s_ls_in;
            cnt_d    = 3'd0;
            res_d    = '0;
            wflush_d = 1'b0;
            mem_a_d  = addr_ls_in;
            if (wr_ls_in) begin
              state_d    = StWrite;
              mem_wr_d   = 1'b1;
              mem_dout_d = data_s_ls_in[7:0];
            end else begin
              state_d = StRead;
            end
          end
        end
        StRead: begin
          if (refresh_rob_cdb_in) begin
            state_d = StIdle;
          end else begin
            res_d = res_cap;
            cnt_d = k;
            if (k == len_q) begin
              data_l_d = res_cap;
              pulse_d  = 1'b1;
              state_d  = StDone;
            end else begin
              mem_a_d = addr_next;
            end
          end
        end
        StWrite: begin
          // A flushed store still drains, since it is already committed.
          if (refresh_rob_cdb_in) wflush_d = 1'b1;
          if (io_stall) begin
            mem_wr_d = 1'b0;
          end else if (!mem_wr_q) begin
            mem_wr_d = 1'b1;
          end else if (k == len_q) begin
            pulse_d = !(wflush_q || refresh_rob_cdb_in);
            state_d = StDone;
          end else begin
            cnt_d      = k;
            mem_a_d    = addr_next;
            mem_dout_d = st_byte;
            mem_wr_d   = 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      addr_q     <= '0;
      data_q     <= '0;
      res_q      <= '0;
      wflush_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'h00;
      mem_wr_q   <= 1'b0;
      pulse_q    <= 1'b0;
      data_l_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      res_q      <= res_d;
      wflush_q   <= wflush_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      pulse_q    <= pulse_d;
      data_l_q   <= data_l_d;
    end
  end

  assign mem_a           = mem_a_q;
  assign mem_dout        = mem_dout_q;
  assign mem_wr          = mem_wr_q;
  assign rdy_data_ls_out = pulse_q;
  assign data_l_ls_out   = data_l_q;

endmodule

// File: tb/tb_ls_mem_responder.sv
// Bench for ls_mem_responder: a byte RAM/IO model plus per-cycle expectations derived
// from each request's address, length and data.
module tb_ls_mem_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rdy_data_ls_in = 1'b0;
  logic        wr_ls_in = 1'b0;
  logic [31:0] addr_ls_in = 32'h0;
  logic [2:0]  len_ls_in = 3'd1;
  logic [31:0] data_s_ls_in = 32'h0;
  logic [31:0] data_l_ls_out;
  logic        rdy_data_ls_out;
  logic        refresh_rob_cdb_in = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  ls_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .rdy_data_ls_in    (rdy_data_ls_in),
    .wr_ls_in          (wr_ls_in),
    .addr_ls_in        (addr_ls_in),
    .len_ls_in         (len_ls_in),
    .data_s_ls_in      (data_s_ls_in),
    .data_l_ls_out     (data_l_ls_out),
    .rdy_data_ls_out   (rdy_data_ls_out),
    .refresh_rob_cdb_in(refresh_rob_cdb_in),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int io_cnt = 0;

  // RAM indexed by the low 16 address bits; IO-space writes only bump a counter.
  logic [7:0] ram [0:65535];
  assign mem_din = ram[mem_a[15:0]];

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h11;
    ram[16'h1001] = 8'h22;
    ram[16'h1002] = 8'h33;
    ram[16'h1003] = 8'h44;
    ram[16'h0003] = 8'hF0;
    ram[16'hFFFF] = 8'h5A;
    ram[16'h0000] = 8'hC3;
    forever begin
      @(posedge clk_in);
      if (mem_wr && !(mem_a[17:16] == 2'b11 && io_buffer_full)) begin
        if (mem_a[17:16] == 2'b11) io_cnt = io_cnt + 1;
        else ram[mem_a[15:0]] = mem_dout;
      end
    end
  end

  logic [31:0] exp_a     [int unsigned];
  logic        exp_wr    [int unsigned];
  logic [7:0]  exp_dout  [int unsigned];
  logic        exp_pulse [int unsigned];
  logic [31:0] exp_data  [int unsigned];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (exp_a.exists(cyc))     chk("mem_a", mem_a, exp_a[cyc]);
    if (exp_wr.exists(cyc))    chk("mem_wr", {31'h0, mem_wr}, {31'h0, exp_wr[cyc]});
    if (exp_dout.exists(cyc))  chk("mem_dout", {24'h0, mem_dout}, {24'h0, exp_dout[cyc]});
    if (exp_pulse.exists(cyc)) chk("pulse", {31'h0, rdy_data_ls_out}, {31'h0, exp_pulse[cyc]});
    if (exp_data.exists(cyc))  chk("load_data", data_l_ls_out, exp_data[cyc]);
  end

  function automatic int unsigned norm_len(input logic [2:0] l);
    return (l >= 3'd1 && l <= 3'd4) ? int'(l) : 4;
  endfunction

  function automatic logic [31:0] ram_rd32(input logic [31:0] a);
    return {24'h0, ram[a[15:0]]};
  endfunction

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk_in);
  endtask

  // Called at a negedge; request is sampled at the following edge E0.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] len, input logic [31:0] lit);
    int unsigned e0, n;
    logic [31:0] d;
    e0 = cyc + 1;
    n = norm_len(len);
    rdy_data_ls_in = 1'b1; wr_ls_in = 1'b0; addr_ls_in = addr; len_ls_in = len;
    data_s_ls_in = 32'hA5A5A5A5;
    d = 32'h0;
    for (int k = 0; k < int'(n); k++) begin
      exp_a[e0 + k] = addr + 32'(k);
      exp_wr[e0 + k] = 1'b0;
      exp_pulse[e0 + k] = 1'b0;
      d = d | (ram_rd32(addr + 32'(k)) << (8 * k));
    end
    exp_wr[e0 + n] = 1'b0;
    exp_pulse[e0 + n] = 1'b1;
    exp_data[e0 + n] = d;
    exp_pulse[e0 + n + 1] = 1'b0;
    wait_cyc(e0 + n);
    chk("load_literal", data_l_ls_out, lit);
    rdy_data_ls_in = 1'b0;
    wait_cyc(e0 + n + 1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] len, input logic [31:0] data);
    int unsigned e0, n;
    e0 = cyc + 1;
    n = norm_len(len);
    rdy_data_ls_in = 1'b1; wr_ls_in = 1'b1; addr_ls_in = addr; len_ls_in = len;
    data_s_ls_in = data;
    for (int k = 0; k < int'(n); k++) begin
      exp_a[e0 + k] = addr + 32'(k);
      exp_wr[e0 + k] = 1'b1;
      exp_dout[e0 + k] = data[8 * k +: 8];
      exp_pulse[e0 + k] = 1'b0;
    end
    exp_wr[e0 + n] = 1'b0;
    exp_pulse[e0 + n] = 1'b1;
    exp_pulse[e0 + n + 1] = 1'b0;
    wait_cyc(e0 + n);
    rdy_data_ls_in = 1'b0; wr_ls_in = 1'b0;
    wait_cyc(e0 + n + 1);
    for (int k = 0; k < int'(n); k++)
      chk("store_ram", ram_rd32(addr + 32'(k)), {24'h0, data[8 * k +: 8]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    int io_base;
    #1 rst_in = 1'b0;
    #1;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_pulse", {31'h0, rdy_data_ls_out}, 32'h0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;

    do_load(32'h0000_1000, 3'd4, 32'h4433_2211);
    do_load(32'h0000_0003, 3'd1, 32'h0000_00F0);
    do_store(32'h0000_0200, 3'd2, 32'hDEAD_BEEF);
    chk("store_lit_lo", ram_rd32(32'h200), 32'h0000_00EF);
    chk("store_lit_hi", ram_rd32(32'h201), 32'h0000_00BE);
    chk("store_len_bound", ram_rd32(32'h202), 32'h0000_0000);

    // IO store stalled by a full buffer for three edges.
    io_base = io_cnt;
    e0 = cyc + 1;
    rdy_data_ls_in = 1'b1; wr_ls_in = 1'b1; addr_ls_in = 32'h0003_0000; len_ls_in = 3'd1;
    data_s_ls_in = 32'h0000_00AB;
    for (int k = 0; k < 5; k++) begin
      exp_a[e0 + k] = 32'h0003_0000;
      exp_dout[e0 + k] = 8'hAB;
      exp_pulse[e0 + k] = 1'b0;
    end
    exp_wr[e0] = 1'b1;
    for (int k = 1; k < 4; k++) exp_wr[e0 + k] = 1'b0;
    exp_wr[e0 + 4] = 1'b1;
    exp_wr[e0 + 5] = 1'b0;
    exp_pulse[e0 + 5] = 1'b1;
    exp_pulse[e0 + 6] = 1'b0;
    wait_cyc(e0); io_buffer_full = 1'b1;
    wait_cyc(e0 + 3); io_buffer_full = 1'b0;
    wait_cyc(e0 + 5); rdy_data_ls_in = 1'b0; wr_ls_in = 1'b0;
    wait_cyc(e0 + 6);
    chk("io_single_write", 32'(io_cnt - io_base), 32'd1);

    // Load flushed at E0+2; the held request (retargeted) is accepted at E0+3.
    e0 = cyc + 1;
    rdy_data_ls_in = 1'b1; wr_ls_in = 1'b0; addr_ls_in = 32'h0000_1000; len_ls_in = 3'd4;
    exp_a[e0] = 32'h1000;
    exp_a[e0 + 1] = 32'h1001;
    for (int k = 0; k < 4; k++) exp_pulse[e0 + k] = 1'b0;
    exp_a[e0 + 3] = 32'h0000_0003;
    exp_pulse[e0 + 4] = 1'b1;
    exp_data[e0 + 4] = 32'h0000_00F0;
    exp_pulse[e0 + 5] = 1'b0;
    wait_cyc(e0 + 1); refresh_rob_cdb_in = 1'b1;
    wait_cyc(e0 + 2); refresh_rob_cdb_in = 1'b0; addr_ls_in = 32'h0000_0003; len_ls_in = 3'd1;
    wait_cyc(e0 + 4); rdy_data_ls_in = 1'b0;
    wait_cyc(e0 + 5);

    do_load(32'hFFFF_FFFF, 3'd2, 32'h0000_C35A);
    do_load(32'h0000_1000, 3'd0, 32'h4433_2211);
    do_store(32'h0000_0500, 3'd7, 32'h1234_5678);

    // rdy_in low at edges E0+1 and E0+4: one stretched step, one held pulse.
    e0 = cyc + 1;
    rdy_data_ls_in = 1'b1; wr_ls_in = 1'b0; addr_ls_in = 32'h0000_1000; len_ls_in = 3'd2;
    exp_a[e0] = 32'h1000;
    exp_a[e0 + 1] = 32'h1000;
    exp_a[e0 + 2] = 32'h1001;
    for (int k = 0; k < 4; k++) exp_wr[e0 + k] = 1'b0;
    for (int k = 0; k < 3; k++) exp_pulse[e0 + k] = 1'b0;
    exp_pulse[e0 + 3] = 1'b1;
    exp_data[e0 + 3] = 32'h0000_2211;
    exp_pulse[e0 + 4] = 1'b1;
    exp_data[e0 + 4] = 32'h0000_2211;
    exp_pulse[e0 + 5] = 1'b0;
    wait_cyc(e0); rdy_in = 1'b0;
    wait_cyc(e0 + 1); rdy_in = 1'b1;
    wait_cyc(e0 + 3); rdy_data_ls_in = 1'b0; rdy_in = 1'b0;
    wait_cyc(e0 + 4); rdy_in = 1'b1;
    wait_cyc(e0 + 5);

    // Store flushed at E0+1: all bytes still written, pulse suppressed.
    e0 = cyc + 1;
    rdy_data_ls_in = 1'b1; wr_ls_in = 1'b1; addr_ls_in = 32'h0000_0600; len_ls_in = 3'd3;
    data_s_ls_in = 32'h00AB_CDEF;
    for (int k = 0; k < 3; k++) begin
      exp_a[e0 + k] = 32'h600 + 32'(k);
      exp_wr[e0 + k] = 1'b1;
      exp_pulse[e0 + k] = 1'b0;
    end
    exp_dout[e0] = 8'hEF;
    exp_dout[e0 + 1] = 8'hCD;
    exp_dout[e0 + 2] = 8'hAB;
    exp_wr[e0 + 3] = 1'b0;
    exp_pulse[e0 + 3] = 1'b0;
    exp_pulse[e0 + 4] = 1'b0;
    wait_cyc(e0); refresh_rob_cdb_in = 1'b1; rdy_data_ls_in = 1'b0; wr_ls_in = 1'b0;
    wait_cyc(e0 + 1); refresh_rob_cdb_in = 1'b0;
    wait_cyc(e0 + 5);
    chk("flush_store_b2", ram_rd32(32'h602), 32'h0000_00AB);

    // Reset asserted between edges while a store is in flight.
    e0 = cyc + 1;
    rdy_data_ls_in = 1'b1; wr_ls_in = 1'b1; addr_ls_in = 32'h0000_0300; len_ls_in = 3'd4;
    data_s_ls_in = 32'h4455_6677;
    exp_a[e0] = 32'h300;
    exp_wr[e0] = 1'b1;
    exp_dout[e0] = 8'h77;
    exp_a[e0 + 1] = 32'h301;
    exp_wr[e0 + 1] = 1'b1;
    exp_dout[e0 + 1] = 8'h66;
    wait_cyc(e0 + 1);
    #2 rst_in = 1'b0;
    #1;
    chk("rst_mid_mem_a", mem_a, 32'h0);
    chk("rst_mid_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_mid_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_mid_data_l", data_l_ls_out, 32'h0);
    chk("rst_mid_pulse", {31'h0, rdy_data_ls_out}, 32'h0);
    rdy_data_ls_in = 1'b0; wr_ls_in = 1'b0;
    wait_cyc(e0 + 2);
    rst_in = 1'b1;
    exp_wr[e0 + 3] = 1'b0;
    exp_pulse[e0 + 3] = 1'b0;
    wait_cyc(e0 + 4);
    chk("rst_mid_byte0", ram_rd32(32'h300), 32'h0000_0077);
    chk("rst_mid_byte1", ram_rd32(32'h301), 32'h0000_0000);

    @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
